cnn_layer_sequencer: RTL

Control FSM that sequences one shared multiply-accumulate (MAC) datapath over the whole inference of one image. It runs the convolution phase first: 8 filters of 5x5 over the 28x28 image, giving 24x24 outputs per filter. It then waits for the external pool stage to finish. Last it runs the fully-connected phase: 10 classes by 1152 inputs. For each MAC beat it emits image, conv-weight and fc-weight indices plus accumulate framing. It sits between the preloaded data/weight arrays and the MAC unit.

---
 rtl/cnn_pkg.sv | 32 +++
 rtl/conv_window_counter.sv | 92 +++++++++
 rtl/cnn_layer_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared dimensions, field widths and encodings for the CNN layer sequencer.
package cnn_pkg;

    localparam int unsigned IMG_DIM = 28;
    localparam int unsigned K_DIM   = 5;
    localparam int unsigned N_FILT  = 8;
    localparam int unsigned N_CLASS = 10;
    localparam int unsigned FC_LEN  = 1152;
    localparam int unsigned OUT_DIM = IMG_DIM - K_DIM + 1;

    localparam int unsigned FILT_W  = $clog2(N_FILT);
    localparam int unsigned POS_W   = $clog2(IMG_DIM);
    localparam int unsigned K_W     = $clog2(K_DIM);
    localparam int unsigned CLASS_W = $clog2(N_CLASS);
    localparam int unsigned IDX_W   = $clog2(FC_LEN);

    typedef enum logic [1:0] {
        PH_IDLE      = 2'd0,
        PH_CONV      = 2'd1,
        PH_WAIT_POOL = 2'd2,
        PH_FC        = 2'd3
    } phase_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_WAIT_POOL,
        S_FC,
        S_DONE
    } state_e;

endpackage

// File: rtl/conv_window_counter.sv
// Five-level filt/out_row/out_col/kr/kc counter for the conv phase.
// Indices are registered; the flags are decodes of the current position.
module conv_window_counter
    import cnn_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    output logic [FILT_W-1:0] filt,
    output logic [POS_W-1:0]  out_row,
    output logic [POS_W-1:0]  out_col,
    output logic [POS_W-1:0]  img_row,
    output logic [POS_W-1:0]  img_col,
    output logic [K_W-1:0]    wgt_row,
    output logic [K_W-1:0]    wgt_col,
    output logic              last_c,
    output logic              pre_last_c,
    output logic              wrap_c
);

    logic [FILT_W-1:0] filt_n;
    logic [POS_W-1:0]  row_n;
    logic [POS_W-1:0]  col_n;
    logic [K_W-1:0]    kr_n;
    logic [K_W-1:0]    kc_n;
    logic              kc_end;
    logic              kr_end;
    logic              col_end;
    logic              row_end;
    logic              filt_end;

    assign kc_end   = (wgt_col == K_W'(K_DIM - 1));
    assign kr_end   = (wgt_row == K_W'(K_DIM - 1));
    assign col_end  = (out_col == POS_W'(OUT_DIM - 1));
    assign row_end  = (out_row == POS_W'(OUT_DIM - 1));
    assign filt_end = (filt == FILT_W'(N_FILT - 1));

    assign last_c     = kr_end & kc_end;
    assign pre_last_c = kr_end & (wgt_col == K_W'(K_DIM - 2));
    assign wrap_c     = filt_end & row_end & col_end & kr_end & kc_end;

    // Ripple-carry style next position; the final wrap lands back on all zeros.
    always_comb begin
        filt_n = filt;
        row_n  = out_row;
        col_n  = out_col;
        kr_n   = wgt_row;
        kc_n   = wgt_col;
        if (kc_end) begin
            kc_n = '0;
            if (kr_end) begin
                kr_n = '0;
                if (col_end) begin
                    col_n = '0;
                    if (row_end) begin
                        row_n  = '0;
                        filt_n = filt_end ? '0 : filt + FILT_W'(1);
                    end else begin
                        row_n = out_row + POS_W'(1);
                    end
                end else begin
                    col_n = out_col + POS_W'(1);
                end
            end else begin
                kr_n = wgt_row + K_W'(1);
            end
        end else begin
            kc_n = wgt_col + K_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            filt    <= '0;
            out_row <= '0;
            out_col <= '0;
            img_row <= '0;
            img_col <= '0;
            wgt_row <= '0;
            wgt_col <= '0;
        end else if (advance) begin
            filt    <= filt_n;
            out_row <= row_n;
            out_col <= col_n;
            img_row <= row_n + POS_W'(kr_n);
            img_col <= col_n + POS_W'(kc_n);
            wgt_row <= kr_n;
            wgt_col <= kc_n;
        end
    end

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Sequences one shared MAC over conv (8x24x24 windows of 5x5), a pool wait,
// then FC (10 classes x 1152 inputs) for a single image inference.
module cnn_layer_sequencer
    import cnn_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               pool_done,
    input  logic               mac_ready,
    output logic               busy,
    output logic               done,
    output logic [1:0]         phase,
    output logic               mac_valid,
    output logic               mac_first,
    output logic               mac_last,
    output logic [FILT_W-1:0]  filt,
    output logic [POS_W-1:0]   out_row,
    output logic [POS_W-1:0]   out_col,
    output logic [POS_W-1:0]   img_row,
    output logic [POS_W-1:0]   img_col,
    output logic [K_W-1:0]     wgt_row,
    output logic [K_W-1:0]     wgt_col,
    output logic [CLASS_W-1:0] fc_class,
    output logic [IDX_W-1:0]   fc_idx
);

    state_e state;
    logic   beat;
    logic   conv_adv;
    logic   conv_last_c;
    logic   conv_pre_last_c;
    logic   conv_wrap_c;
    logic   fc_idx_last;
    logic   fc_idx_pre_last;
    logic   fc_class_last;

    assign beat            = mac_valid & mac_ready;
    assign conv_adv        = (state == S_CONV) & beat;
    assign fc_idx_last     = (fc_idx == IDX_W'(FC_LEN - 1));
    assign fc_idx_pre_last = (fc_idx == IDX_W'(FC_LEN - 2));
    assign fc_class_last   = (fc_class == CLASS_W'(N_CLASS - 1));

    conv_window_counter u_conv (
        .clk        (clk),
        .rst        (rst),
        .advance    (conv_adv),
        .filt       (filt),
        .out_row    (out_row),
        .out_col    (out_col),
        .img_row    (img_row),
        .img_col    (img_col),
        .wgt_row    (wgt_row),
        .wgt_col    (wgt_col),
        .last_c     (conv_last_c),
        .pre_last_c (conv_pre_last_c),
        .wrap_c     (conv_wrap_c)
    );

    // Framing flags are looked ahead one beat so they stay registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            phase     <= PH_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mac_valid <= 1'b0;
            mac_first <= 1'b0;
            mac_last  <= 1'b0;
            fc_class  <= '0;
            fc_idx    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_CONV;
                        phase     <= PH_CONV;
                        busy      <= 1'b1;
                        mac_valid <= 1'b1;
                        mac_first <= 1'b1;
                        mac_last  <= 1'b0;
                    end
                end
                S_CONV: begin
                    if (beat) begin
                        if (conv_wrap_c) begin
                            state     <= S_WAIT_POOL;
                            phase     <= PH_WAIT_POOL;
                            mac_valid <= 1'b0;
                            mac_first <= 1'b0;
                            mac_last  <= 1'b0;
                        end else begin
                            mac_first <= conv_last_c;
                            mac_last  <= conv_pre_last_c;
                        end
                    end
                end
                S_WAIT_POOL: begin
                    if (pool_done) begin
                        state     <= S_FC;
                        phase     <= PH_FC;
                        mac_valid <= 1'b1;
                        mac_first <= 1'b1;
                        mac_last  <= 1'b0;
                    end
                end
                S_FC: begin
                    if (beat) begin
                        if (fc_idx_last) begin
                            fc_idx <= '0;
                            if (fc_class_last) begin
                                state     <= S_DONE;
                                fc_class  <= '0;
                                mac_valid <= 1'b0;
                                mac_first <= 1'b0;
                                mac_last  <= 1'b0;
                                done      <= 1'b1;
                            end else begin
                                fc_class  <= fc_class + CLASS_W'(1);
                                mac_first <= 1'b1;
                                mac_last  <= 1'b0;
                            end
                        end else begin
                            fc_idx    <= fc_idx + IDX_W'(1);
                            mac_first <= 1'b0;
                            mac_last  <= fc_idx_pre_last;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    phase <= PH_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    phase     <= PH_IDLE;
                    busy      <= 1'b0;
                    mac_valid <= 1'b0;
                    mac_first <= 1'b0;
                    mac_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule
